// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for push-button input blocks.
//   key_state_e        : debounce FSM states (LOW, RISE, HIGH, FALL)
//   STABLE_CYCLES_DEF  : default qualification length in synchronized cycles
//   CNT_W_DEF          : default width of the accepted-press counter
// -----------------------------------------------------------------------------
package key_pkg;

   typedef enum logic [1:0] {
      LOW  = 2'd0,
      RISE = 2'd1,
      HIGH = 2'd2,
      FALL = 2'd3
   } key_state_e;

   localparam int STABLE_CYCLES_DEF = 4;
   localparam int CNT_W_DEF         = 8;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears both flops
//   d     : asynchronous input level
//   q     : synchronized level (second flop)
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces a raw push-button level. A new level is accepted only after it has
// been seen on the synchronized input for STABLE_CYCLES consecutive cycles.
// Ports:
//   clk           : clock, all state updates on rising edge
//   rst_n         : synchronous active-low reset
//   key           : raw asynchronous key level (1 = pressed)
//   key_level     : debounced key level
//   press_pulse   : one-cycle strobe on accepted 0->1 transition
//   release_pulse : one-cycle strobe on accepted 1->0 transition
//   press_count   : accepted presses since reset, wraps silently
//   busy          : high while a candidate transition is being qualified
// -----------------------------------------------------------------------------
module key_debounce
   import key_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key,
   output logic             key_level,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic [CNT_W-1:0] press_count,
   output logic             busy
);

   // Terminal value of the qualification counter.
   localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
   // A single-cycle qualification skips RISE/FALL entirely.
   localparam bit         DIRECT   = (STABLE_CYCLES == 1);

   logic             ks;

   key_state_e       state_q,       state_d;
   logic [7:0]       stab_cnt_q,    stab_cnt_d;
   logic             press_q,       press_d;
   logic             release_q,     release_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;

   sync2 u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key),
      .q     (ks)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= LOW;
         stab_cnt_q    <= 8'd0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         press_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stab_cnt_q    <= stab_cnt_d;
         press_q       <= press_d;
         release_q     <= release_d;
         press_count_q <= press_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      stab_cnt_d    = stab_cnt_q;
      press_d       = 1'b0;
      release_d     = 1'b0;
      press_count_d = press_count_q;

      unique case (state_q)
         LOW: begin
            if (ks) begin
               if (DIRECT) begin
                  state_d       = HIGH;
                  press_d       = 1'b1;
                  press_count_d = press_count_q + CNT_W'(1);
               end else begin
                  // The first qualifying sample counts as cycle one.
                  state_d    = RISE;
                  stab_cnt_d = 8'd1;
               end
            end
         end
         RISE: begin
            if (!ks) begin
               state_d    = LOW;
               stab_cnt_d = 8'd0;
            end else if (stab_cnt_q == LAST_CNT) begin
               state_d       = HIGH;
               stab_cnt_d    = 8'd0;
               press_d       = 1'b1;
               press_count_d = press_count_q + CNT_W'(1);
            end else begin
               stab_cnt_d = stab_cnt_q + 8'd1;
            end
         end
         HIGH: begin
            if (!ks) begin
               if (DIRECT) begin
                  state_d   = LOW;
                  release_d = 1'b1;
               end else begin
                  state_d    = FALL;
                  stab_cnt_d = 8'd1;
               end
            end
         end
         FALL: begin
            if (ks) begin
               state_d    = HIGH;
               stab_cnt_d = 8'd0;
            end else if (stab_cnt_q == LAST_CNT) begin
               state_d    = LOW;
               stab_cnt_d = 8'd0;
               release_d  = 1'b1;
            end else begin
               stab_cnt_d = stab_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = LOW;
            stab_cnt_d = 8'd0;
         end
      endcase
   end

   assign key_level     = (state_q == HIGH) || (state_q == FALL);
   assign busy          = (state_q == RISE) || (state_q == FALL);
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign press_count   = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Two instances share clock, reset and key: one with default parameters, one
// with STABLE_CYCLES=1 and a 2-bit counter. A run-length reference model
// predicts every cycle's outputs; a negedge monitor compares against them.
// -----------------------------------------------------------------------------
module tb_key_debounce;

   logic clk = 1'b0;
   logic rst_n;
   logic key;

   logic       lvl_a, prs_a, rel_a, busy_a;
   logic [7:0] cnt_a;
   logic       lvl_b, prs_b, rel_b, busy_b;
   logic [1:0] cnt_b;

   always #5 clk = ~clk;

   key_debounce #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (key),
      .key_level     (lvl_a),
      .press_pulse   (prs_a),
      .release_pulse (rel_a),
      .press_count   (cnt_a),
      .busy          (busy_a)
   );

   key_debounce #(.STABLE_CYCLES(1), .CNT_W(2)) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .key           (key),
      .key_level     (lvl_b),
      .press_pulse   (prs_b),
      .release_pulse (rel_b),
      .press_count   (cnt_b),
      .busy          (busy_b)
   );

   typedef struct packed {
      logic [11:0] a;
      logic [5:0]  b;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;
   int   cycle  = 0;

   // Reference model: two-sample delay on key, then count how long the
   // delayed key has disagreed with the accepted level; flip at S samples.
   logic m_s1[2], m_s2[2], m_lvl[2], m_pr[2], m_rl[2];
   int   m_run[2], m_cnt[2];
   int   m_S[2]   = '{4, 1};
   int   m_mod[2] = '{256, 4};

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pr[i] = 0; m_rl[i] = 0;
         m_run[i] = 0; m_cnt[i] = 0;
      end
   end

   always @(posedge clk) begin
      exp_t e;
      logic ks;
      cycle++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pr[i] = 0; m_rl[i] = 0;
            m_run[i] = 0; m_cnt[i] = 0;
         end else begin
            ks      = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = key;
            m_pr[i] = 0;
            m_rl[i] = 0;
            if (ks != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == m_S[i]) begin
                  m_lvl[i] = ks;
                  m_run[i] = 0;
                  if (ks) begin
                     m_pr[i]  = 1;
                     m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
                  end else begin
                     m_rl[i] = 1;
                  end
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      e.a = {m_lvl[0], m_pr[0], m_rl[0], (m_run[0] != 0), 8'(m_cnt[0])};
      e.b = {m_lvl[1], m_pr[1], m_rl[1], (m_run[1] != 0), 2'(m_cnt[1])};
      exp_q.push_back(e);
   end

   // Monitor: one expectation per clock edge, compared half a cycle later.
   always @(negedge clk) begin
      exp_t e;
      logic [11:0] got_a;
      logic [5:0]  got_b;
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL scoreboard_empty cycle %0d: no expectation queued", cycle);
      end else begin
         e     = exp_q.pop_front();
         got_a = {lvl_a, prs_a, rel_a, busy_a, cnt_a};
         got_b = {lvl_b, prs_b, rel_b, busy_b, cnt_b};
         total++;
         if (got_a === e.a) passed++;
         else $display("FAIL dut_a cycle %0d: got lvl/prs/rel/busy/cnt=%b required %b",
                       cycle, got_a, e.a);
         total++;
         if (got_b === e.b) passed++;
         else $display("FAIL dut_b cycle %0d: got lvl/prs/rel/busy/cnt=%b required %b",
                       cycle, got_b, e.b);
      end
   end

   task automatic hold(input logic v, input int n);
      key = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      key   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      hold(0, 4);
      // clean press then release
      hold(1, 12);
      hold(0, 12);
      // bounce on press
      hold(1, 2); hold(0, 1); hold(1, 12);
      // reset while qualifying a release, then key held high
      hold(0, 3);
      do_reset(1);
      hold(1, 12);
      hold(0, 12);
      // pulses shorter than the qualification window
      for (int n = 1; n <= 3; n++) begin
         hold(1, n);
         hold(0, 8);
      end
      // short release glitch while held
      hold(1, 12); hold(0, 1); hold(1, 12); hold(0, 12);
      // five clean presses to wrap the 2-bit counter
      for (int n = 0; n < 5; n++) begin
         hold(1, 8);
         hold(0, 8);
      end
      // randomized key activity with occasional reset
      repeat (200) begin
         hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
         if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 2));
      end
      hold(0, 10);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
